// File: rtl/pwm_dac_pkg.sv
// Shared types and constants for the PWM DAC output stage.
// No logic; no latency; no backpressure.
// Amplitude codes are consumed only when PWM_AMP_SCALE_EN is defined.
package pwm_dac_pkg;

    localparam int PWM_DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        AMP_FULL    = 2'b00,
        AMP_HALF    = 2'b01,
        AMP_QUARTER = 2'b10,
        AMP_MUTE    = 2'b11
    } amp_sel_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk into a one-clock tick every PRESCALE clocks.
// Latency: tick is combinational from the pre-counter register.
// Backpressure: none, free-running.
module pwm_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    // With PRESCALE=1 pre never leaves 0, so tick is held high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
        end else if (pre == PRE_LAST) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    assign tick = (pre == PRE_LAST);

endmodule

// File: rtl/pwm_dac.sv
// Sample-to-PWM converter for the board RC DAC; optional amp scaling via PWM_AMP_SCALE_EN.
// Latency: 1 clock from the wrap edge to pwm_out reflecting the new duty.
// Backpressure: none; sample_in (and amp) must be stable at the sample_req wrap edge.
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int WIDTH    = PWM_DEF_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,
`ifdef PWM_AMP_SCALE_EN
    input  logic [1:0]       amp,
`endif
    output logic             sample_req,
    output logic             pwm_out
);

    // Last count of a period is 2^WIDTH-2, giving 2^WIDTH-1 ticks per period.
    localparam logic [WIDTH-1:0] CNT_MAX = {{(WIDTH-1){1'b1}}, 1'b0};

    logic             tick;
    logic             wrap;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] scaled;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign wrap = tick && (cnt == CNT_MAX);

`ifdef PWM_AMP_SCALE_EN
    always_comb begin
        scaled = sample_in;
        case (amp_sel_t'(amp))
            AMP_FULL:    scaled = sample_in;
            AMP_HALF:    scaled = sample_in >> 1;
            AMP_QUARTER: scaled = sample_in >> 2;
            default:     scaled = '0;
        endcase
    end
`else
    assign scaled = sample_in;
`endif

    // Compare uses pre-edge cnt/duty, so a new duty shows up one clock after the wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            duty       <= '0;
            sample_req <= 1'b0;
            pwm_out    <= 1'b0;
        end else begin
            sample_req <= wrap;
            pwm_out    <= (cnt < duty);
            if (wrap) begin
                cnt  <= '0;
                duty <= scaled;
            end else if (tick) begin
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac: default-prescale and PRESCALE=4 instances against a clock-count reference model.
module tb_pwm_dac;

    localparam int P0 = 255;
    localparam int P4 = 1020;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] s0  = '0;
    logic [7:0] s4  = '0;
    logic [1:0] amp = '0;
    logic       req0, pwm0, req4, pwm4;

    int errors = 0;
    int checks = 0;
    int n      = 0;
    int d0     = 0;
    int d4     = 0;
    int hi0    = 0;
    int hi4    = 0;
    int rq0    = 0;
    int rq4    = 0;
    bit e_pwm0, e_req0, e_pwm4, e_req4;

    always #5 clk = ~clk;

    pwm_dac #(.WIDTH(8), .PRESCALE(1)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .sample_in  (s0),
`ifdef PWM_AMP_SCALE_EN
        .amp        (amp),
`endif
        .sample_req (req0),
        .pwm_out    (pwm0)
    );

    pwm_dac #(.WIDTH(8), .PRESCALE(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .sample_in  (s4),
`ifdef PWM_AMP_SCALE_EN
        .amp        (amp),
`endif
        .sample_req (req4),
        .pwm_out    (pwm4)
    );

    function automatic int scale(int x);
`ifdef PWM_AMP_SCALE_EN
        case (amp)
            2'd0:    return x;
            2'd1:    return x / 2;
            2'd2:    return x / 4;
            default: return 0;
        endcase
`else
        return x;
`endif
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model: after edge n (counted from reset release), output reflects the tick
    // index of edge n-1 against the duty latched at the last wrap before edge n.
    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            n++;
            e_pwm0 = (((n - 1) % P0) < d0);
            e_pwm4 = ((((n - 1) % P4) / 4) < d4);
            e_req0 = ((n % P0) == 0);
            e_req4 = ((n % P4) == 0);
            if (e_req0) d0 = scale(s0);
            if (e_req4) d4 = scale(s4);
        end else begin
            e_pwm0 = 1'b0;
            e_pwm4 = 1'b0;
            e_req0 = 1'b0;
            e_req4 = 1'b0;
        end
        @(negedge clk);
        check("pwm0", pwm0, e_pwm0);
        check("req0", req0, e_req0);
        check("pwm4", pwm4, e_pwm4);
        check("req4", req4, e_req4);
        hi0 += int'(pwm0);
        hi4 += int'(pwm4);
        rq0 += int'(req0);
        rq4 += int'(req4);
    endtask

    task automatic run(int k);
        for (int i = 0; i < k; i++) cyc();
    endtask

    task automatic to_wrap(int per);
        for (int i = 0; i < 2 * P4; i++) begin
            cyc();
            if (rst && (n % per) == 0) break;
        end
    endtask

    initial begin
        int r;
        int expv;

        // Reset held for 20 clocks, then release with sample 0.
        s0 = 8'd0;
        s4 = 8'd64;
        run(20);
        rst = 1'b1;
        rq0 = 0;
        run(254);
        check("no_early_req", rq0, 0);
        cyc();
        check("first_req", req0, 1);
        hi0 = 0;
        rq0 = 0;
        s0  = 8'd128;
        run(255);
        check("first_periods_low", hi0, 0);
        check("req_per_period", rq0, 1);

        // Steady duty 128: high starts one clock after the wrap edge.
        hi0 = 0;
        cyc();
        check("hi_start", pwm0, 1);
        s0 = 8'd255;
        run(254);
        check("duty128_hi", hi0, 128);

        // Extremes.
        hi0 = 0;
        s0  = 8'd0;
        run(255);
        check("duty255_hi", hi0, 255);
        hi0 = 0;
        s0  = 8'd200;
        run(255);
        check("duty0_hi", hi0, 0);

        // Mid-period change at cnt=50 ignored until the next wrap.
        hi0 = 0;
        run(51);
        s0 = 8'd10;
        run(204);
        check("midchange_hold", hi0, 200);
        hi0 = 0;
        run(255);
        check("midchange_next", hi0, 10);

        // Prescaler 4, sample 64.
        to_wrap(P4);
        hi4 = 0;
        rq4 = 0;
        run(P4);
        check("pre4_hi", hi4, 256);
        check("pre4_reqs", rq4, 1);

`ifdef PWM_AMP_SCALE_EN
        // Amplitude scaling of 200; amp changed mid-period to a decoy first.
        to_wrap(P0);
        s0  = 8'd200;
        amp = 2'd1;
        run(255);
        for (int a = 2; a <= 4; a++) begin
            hi0  = 0;
            expv = (a == 2) ? 100 : (a == 3) ? 50 : 0;
            amp  = 2'd0;
            run(100);
            amp  = (a == 4) ? 2'd0 : 2'(a);
            run(155);
            check("amp_hi", hi0, expv);
        end
`endif

        // Randomized samples with mid-period decoys.
        to_wrap(P0);
        s0 = 8'($urandom_range(0, 255));
`ifdef PWM_AMP_SCALE_EN
        amp = 2'($urandom_range(0, 3));
`endif
        expv = scale(int'(s0));
        run(255);
        for (int k = 0; k < 8; k++) begin
            hi0 = 0;
            s0  = 8'($urandom_range(0, 255));
`ifdef PWM_AMP_SCALE_EN
            amp = 2'($urandom_range(0, 3));
`endif
            run(120);
            r  = int'($urandom_range(0, 255));
            s0 = 8'(r);
`ifdef PWM_AMP_SCALE_EN
            amp = 2'($urandom_range(0, 3));
`endif
            run(135);
            check("rand_hi", hi0, expv);
            expv = scale(r);
        end

        // Reset asserted mid-period while high.
        s0 = 8'd128;
`ifdef PWM_AMP_SCALE_EN
        amp = 2'd0;
`endif
        run(255);
        to_wrap(P0);
        run(61);
        check("pre_reset_high", pwm0, 1);
        #2;
        rst = 1'b0;
        n   = 0;
        d0  = 0;
        d4  = 0;
        #1;
        check("async_rst_pwm", pwm0, 0);
        check("async_rst_pwm4", pwm4, 0);
        run(5);
        rst = 1'b1;
        hi0 = 0;
        run(255);
        check("post_reset_low", hi0, 0);
        hi0 = 0;
        run(255);
        check("post_reset_duty", hi0, 128);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
